// File: rtl/sdram_rr_arbiter.sv
// Arbitrates one SDRAM read port among N_REQ segment requesters: aged requesters first,
// then fixed priority, then round-robin. One transaction in flight, ack/valid routed to owner.
module sdram_rr_arbiter #(
  parameter int N_REQ      = 8,
  parameter int ADDR_WIDTH = 23,
  parameter int N_PRIO     = 2,
  parameter int STARVE_MAX = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   addr,
  input  logic                          hold,
  output logic [N_REQ-1:0]              ack,
  output logic [N_REQ-1:0]              valid,
  output logic [ADDR_WIDTH-1:0]         sdram_addr,
  output logic                          sdram_req,
  input  logic                          sdram_ack,
  input  logic                          sdram_valid,
  output logic                          busy,
  output logic [$clog2(N_REQ)-1:0]      owner
);

  localparam int IW     = $clog2(N_REQ);
  localparam int AGW    = $clog2(STARVE_MAX + 1);
  localparam int N_RR   = N_REQ - N_PRIO;
  localparam int N_RR_S = (N_RR > 0) ? N_RR : 1;
  localparam logic [AGW-1:0] AGE_MAX  = AGW'(STARVE_MAX);
  localparam logic [IW-1:0]  PRIO_IDX = IW'(N_PRIO);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                 state_reg;
  logic [IW-1:0]          rr_ptr_reg;
  logic [AGW-1:0]         age_reg  [N_REQ];
  logic [AGW-1:0]         age_next [N_REQ];
  logic [ADDR_WIDTH-1:0]  addr_arr [N_REQ];
  logic [IW-1:0]          win;
  logic                   win_found;
  logic                   grant;

  // Ages only move on a grant: the winner restarts, waiting requesters get older.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign addr_arr[gi] = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign age_next[gi] = (win == IW'(gi))          ? '0 :
                            !req[gi]                  ? '0 :
                            (age_reg[gi] == AGE_MAX)  ? AGE_MAX :
                                                        age_reg[gi] + 1'b1;
    end
  endgenerate

  always_comb begin
    logic [IW-1:0] idx;
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req[i] && age_reg[i] == AGE_MAX) begin
        win       = IW'(i);
        win_found = 1'b1;
      end
    end
    for (int i = 0; i < N_PRIO; i++) begin
      if (!win_found && req[i]) begin
        win       = IW'(i);
        win_found = 1'b1;
      end
    end
    // Round-robin search starts just past the last RR owner and wraps to N_PRIO.
    for (int k = 0; k < N_RR; k++) begin
      idx = IW'(N_PRIO + ((int'(rr_ptr_reg) - N_PRIO + 1 + k) % N_RR_S));
      if (!win_found && req[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  assign grant = (state_reg == IDLE) && !hold && win_found;
  assign busy  = (state_reg != IDLE);

  always_comb begin
    ack   = '0;
    valid = '0;
    if (state_reg == REQ && sdram_ack)
      ack[owner] = 1'b1;
    if (state_reg != IDLE && sdram_valid)
      valid[owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      owner      <= '0;
      rr_ptr_reg <= IW'(N_PRIO - 1);
      age_reg    <= '{default: '0};
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant) begin
            owner      <= win;
            sdram_addr <= addr_arr[win];
            sdram_req  <= 1'b1;
            age_reg    <= age_next;
            state_reg  <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            if (owner >= PRIO_IDX)
              rr_ptr_reg <= owner;
            state_reg <= sdram_valid ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (sdram_valid)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Bench for sdram_rr_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-written grant orders and timing expectations.
module tb_sdram_rr_arbiter;

  localparam int N    = 8;
  localparam int AW   = 23;
  localparam int NP   = 2;
  localparam int SMAX = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*AW-1:0]   addr = '0;
  logic              hold = 1'b0;
  logic              sdram_ack = 1'b0;
  logic              sdram_valid = 1'b0;
  logic [N-1:0]      ack, valid;
  logic [AW-1:0]     sdram_addr;
  logic              sdram_req, busy;
  logic [$clog2(N)-1:0] owner;

  sdram_rr_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .N_PRIO(NP), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .hold(hold),
    .ack(ack), .valid(valid), .sdram_addr(sdram_addr), .sdram_req(sdram_req),
    .sdram_ack(sdram_ack), .sdram_valid(sdram_valid), .busy(busy), .owner(owner)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: transaction phase 0 idle, 1 request out, 2 waiting for data.
  int           m_phase, m_owner, m_rr;
  int           m_age [N];
  logic [AW-1:0] m_addr;
  logic         m_sreq;
  int           dut_grants[$];
  int           mdl_grants[$];

  // Controller / requester emulation.
  logic [N-1:0] last_ack = '0, pend = '0, reraise = '0;
  int           ack_dly = 1, val_dly = 3, k = -1;
  bit           resp_en = 1'b0;
  logic         prev_sreq = 1'b0;
  int           ack_hits [N];
  int           val_hits [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    int c;
    for (int i = 0; i < N; i++) if (req[i] && m_age[i] == SMAX) return i;
    for (int i = 0; i < NP; i++) if (req[i]) return i;
    c = m_rr;
    repeat (N - NP) begin
      c = (c >= N - 1) ? NP : c + 1;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_advance();
    int w;
    if (reset) begin
      m_phase = 0; m_owner = 0; m_rr = NP - 1; m_addr = '0; m_sreq = 1'b0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
    end else if (m_phase == 0) begin
      if (!hold && req != '0) begin
        w = pick();
        for (int i = 0; i < N; i++)
          m_age[i] = (i == w) ? 0 : (req[i] ? ((m_age[i] < SMAX) ? m_age[i] + 1 : SMAX) : 0);
        m_owner = w;
        m_addr  = addr[w*AW +: AW];
        m_sreq  = 1'b1;
        m_phase = 1;
        mdl_grants.push_back(w);
      end
    end else if (m_phase == 1) begin
      if (sdram_ack) begin
        m_sreq = 1'b0;
        if (m_owner >= NP) m_rr = m_owner;
        m_phase = sdram_valid ? 0 : 2;
      end
    end else if (sdram_valid) begin
      m_phase = 0;
    end
  endtask

  // One clock: model advances on the edge, stimulus changes 1ns later, checks on negedge.
  task automatic step();
    logic [N-1:0] e_ack, e_val;
    @(posedge clk);
    model_advance();
    #1;
    if (resp_en) begin
      sdram_ack = 1'b0;
      sdram_valid = 1'b0;
      if (k < 0 && sdram_req) k = 0;
      if (k >= 0) begin
        if (k == ack_dly) sdram_ack = 1'b1;
        if (k == val_dly) begin sdram_valid = 1'b1; k = -1; end
        else k++;
      end
    end else begin
      k = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (last_ack[i]) begin req[i] = 1'b0; pend[i] = reraise[i]; end
      else if (pend[i]) begin req[i] = 1'b1; pend[i] = 1'b0; end
    end
    @(negedge clk);
    e_ack = '0;
    e_val = '0;
    if (m_phase == 1 && sdram_ack) e_ack[m_owner] = 1'b1;
    if (m_phase != 0 && sdram_valid) e_val[m_owner] = 1'b1;
    check("cycle", {20'd0, sdram_req, busy, owner, ack, valid, sdram_addr},
          {20'd0, m_sreq, (m_phase != 0), 3'(m_owner), e_ack, e_val, m_addr});
    if (sdram_req && !prev_sreq) dut_grants.push_back(int'(owner));
    prev_sreq = sdram_req;
    last_ack = ack;
    for (int i = 0; i < N; i++) begin
      ack_hits[i] += int'(ack[i]);
      val_hits[i] += int'(valid[i]);
    end
  endtask

  task automatic do_reset();
    resp_en = 1'b0;
    reset = 1'b1;
    req = '0; pend = '0; reraise = '0; last_ack = '0;
    hold = 1'b0; sdram_ack = 1'b0; sdram_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    dut_grants.delete();
    mdl_grants.delete();
    for (int i = 0; i < N; i++) begin ack_hits[i] = 0; val_hits[i] = 0; end
    resp_en = 1'b1;
  endtask

  task automatic wait_grants(input string name, input int n, input int budget);
    int c = 0;
    while (dut_grants.size() < n && c < budget) begin step(); c++; end
    check({name, "_grant_count"}, dut_grants.size(), n);
  endtask

  task automatic wait_wait_state(input string name);
    int c = 0;
    while (!(busy && !sdram_req) && c < 30) begin step(); c++; end
    check({name, "_in_wait"}, {busy, sdram_req}, 2'b10);
  endtask

  task automatic drain(input string name);
    int c = 0;
    req = '0; reraise = '0; pend = '0;
    step();
    while (busy && c < 60) begin step(); c++; end
    check({name, "_drained"}, busy, 1'b0);
  endtask

  task automatic cmp_list(input string name, input int exp[$]);
    check({name, "_dut_len"}, dut_grants.size(), exp.size());
    check({name, "_mdl_len"}, mdl_grants.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < dut_grants.size()) check($sformatf("%s_dut_g%0d", name, i), dut_grants[i], exp[i]);
      if (i < mdl_grants.size()) check($sformatf("%s_mdl_g%0d", name, i), mdl_grants[i], exp[i]);
    end
  endtask

  initial begin
    int exp_q[$];
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(32'h100000 + i * 32'h111);

    // 1: single request, latency and one-cycle ack/valid routing
    do_reset();
    check("rst_sdram_req", sdram_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_owner", owner, 0);
    check("rst_sdram_addr", sdram_addr, 0);
    check("rst_ack_valid", {ack, valid}, 0);
    ack_dly = 2; val_dly = 5;
    addr[3*AW +: AW] = 23'h050002;
    req[3] = 1'b1;
    step();
    check("s1_latency_req", sdram_req, 1'b1);
    check("s1_addr", sdram_addr, 23'h050002);
    check("s1_owner", owner, 3);
    repeat (12) step();
    check("s1_ack_cycles", ack_hits[3], 1);
    check("s1_valid_cycles", val_hits[3], 1);
    check("s1_busy_after", busy, 1'b0);
    exp_q = '{3};
    cmp_list("s1", exp_q);

    // 2: fixed priority beats round-robin; ack and valid in the same cycle
    do_reset();
    ack_dly = 1; val_dly = 1;
    req[0] = 1'b1; req[5] = 1'b1;
    wait_grants("s2", 2, 40);
    exp_q = '{0, 5};
    cmp_list("s2", exp_q);
    drain("s2");

    // 3: round-robin rotation across 2..7, wrapping back to 2
    do_reset();
    ack_dly = 1; val_dly = 3;
    req = 8'hFC; reraise = 8'hFC;
    wait_grants("s3", 7, 80);
    exp_q = '{2, 3, 4, 5, 6, 7, 2};
    cmp_list("s3", exp_q);
    drain("s3");

    // 4: requester 4 forced after STARVE_MAX grants to requester 0
    do_reset();
    ack_dly = 1; val_dly = 3;
    req[0] = 1'b1; reraise[0] = 1'b1; req[4] = 1'b1;
    wait_grants("s4", SMAX + 2, 300);
    exp_q = {};
    repeat (SMAX) exp_q.push_back(0);
    exp_q.push_back(4);
    exp_q.push_back(0);
    cmp_list("s4", exp_q);
    drain("s4");

    // 5: hold during WAIT lets the current transaction finish but blocks new grants
    do_reset();
    ack_dly = 1; val_dly = 6;
    req[1] = 1'b1;
    wait_grants("s5", 1, 20);
    wait_wait_state("s5");
    hold = 1'b1;
    req[6] = 1'b1;
    repeat (15) step();
    check("s5_hold_no_grant", dut_grants.size(), 1);
    check("s5_hold_req_low", sdram_req, 1'b0);
    check("s5_hold_done", busy, 1'b0);
    hold = 1'b0;
    step();
    check("s5_release_req", sdram_req, 1'b1);
    check("s5_release_owner", owner, 6);
    drain("s5");

    // 6: reset during WAIT abandons the transaction
    do_reset();
    ack_dly = 1; val_dly = 30;
    req[2] = 1'b1;
    wait_grants("s6", 1, 20);
    wait_wait_state("s6");
    req = '0;
    resp_en = 1'b0;
    sdram_ack = 1'b0; sdram_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("s6_req_after_reset", sdram_req, 1'b0);
    check("s6_busy_after_reset", busy, 1'b0);
    sdram_valid = 1'b1;
    step();
    check("s6_valid_not_routed", valid, 8'h00);
    check("s6_busy_on_valid", busy, 1'b0);
    check("s6_req_on_valid", sdram_req, 1'b0);
    sdram_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
